// File: rtl/block_data_memory_if.sv
// ---------------------------------------------------------------------------
// block_data_memory_if
//   Cache-to-memory block bus used between the data cache and the
//   block-organised data memory.
//
//   Handshake (read/write/busywait):
//     The cache raises read or write with address/writedata and holds
//     all of them until busywait is low in a cycle after the request was
//     taken. If memory is idle, busywait rises in the same cycle the
//     request appears. It stays high through the whole access. It then
//     drops for exactly one cycle, in which readdata is valid for a read.
//     The cache samples readdata at the posedge closing that cycle.
//     Request lines still high in that low cycle belong to the finished
//     request and are ignored.
//
//   Signals
//     read      cache -> mem  block read request
//     write     cache -> mem  block write request (wins if both high)
//     address   cache -> mem  block address
//     writedata cache -> mem  block to store
//     readdata  mem -> cache  block from last completed read (registered)
//     busywait  mem -> cache  request pending / in progress
// ---------------------------------------------------------------------------
interface block_data_memory_if #(
  parameter int ADDR_BITS  = 6,
  parameter int BLOCK_BITS = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_BITS-1:0]  address;
  logic [BLOCK_BITS-1:0] writedata;
  logic [BLOCK_BITS-1:0] readdata;
  logic                  busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );
endinterface

// File: rtl/block_data_memory.sv
// ---------------------------------------------------------------------------
// block_data_memory
//   Block-organised data memory sitting behind the data cache. It services
//   one block read or write per request. Every access spends a fixed
//   ACCESS_CYCLES clock cycles in ACCESS, so cache miss and write-back
//   paths stall the way real main memory would make them stall.
//
//   Ports
//     clock        clock; all state updates on posedge
//     reset        asynchronous, active-high reset
//     mem_bus      slave side of block_data_memory_if
//                  (read/write/address/writedata in; readdata/busywait out)
//     state_debug  current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// ---------------------------------------------------------------------------
module block_data_memory #(
  parameter int ADDR_BITS     = 6,
  parameter int BLOCK_BITS    = 32,
  parameter int ACCESS_CYCLES = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  block_data_memory_if.slave   mem_bus,
  output logic [1:0]           state_debug
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_next;
  logic [CNT_W-1:0]      counter_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [BLOCK_BITS-1:0] data_q;
  logic                  op_write_q;
  logic [BLOCK_BITS-1:0] mem [DEPTH];

  logic request;
  assign request = mem_bus.read | mem_bus.write;

  assign state_debug = state_q;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (request) state_next = ACCESS;
      ACCESS:  if (counter_q == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. In IDLE busywait follows the request lines directly,
  // so the cache stalls in the same cycle it raises a request. Reset
  // forces it low even if the cache is still holding a request.
  always_comb begin
    mem_bus.busywait = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    mem_bus.busywait = request;
        ACCESS:  mem_bus.busywait = 1'b1;
        default: mem_bus.busywait = 1'b0;
      endcase
    end
  end

  // Datapath. The request is captured once in IDLE. ACCESS works only
  // from the captured copy, so the cache may change or drop its lines
  // mid-access without effect. readdata moves only when a read completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_q        <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      op_write_q       <= 1'b0;
      mem_bus.readdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (request) begin
            addr_q     <= mem_bus.address;
            data_q     <= mem_bus.writedata;
            op_write_q <= mem_bus.write;
            counter_q  <= CNT_W'(ACCESS_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (counter_q == '0) begin
            if (op_write_q) begin
              mem[addr_q] <= data_q;
            end else begin
              mem_bus.readdata <= mem[addr_q];
            end
          end else begin
            counter_q <= counter_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// ---------------------------------------------------------------------------
// tb_block_data_memory
//   Directed bench for block_data_memory with ACCESS_CYCLES = 5. Each
//   request is timed from its appearance to the busywait-low cycle. The
//   returned block is compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_block_data_memory;

  localparam int ADDR_BITS     = 6;
  localparam int BLOCK_BITS    = 32;
  localparam int ACCESS_CYCLES = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int MODE_PLAIN    = 0;  // hold request untouched
  localparam int MODE_RETARGET = 1;  // change address/writedata mid-access
  localparam int MODE_WITHDRAW = 2;  // drop read/write mid-access

  logic       clock;
  logic       reset;
  logic [1:0] state_debug;

  int n_checks;
  int n_pass;

  block_data_memory_if #(.ADDR_BITS(ADDR_BITS), .BLOCK_BITS(BLOCK_BITS)) bus ();

  block_data_memory #(
    .ADDR_BITS    (ADDR_BITS),
    .BLOCK_BITS   (BLOCK_BITS),
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_bus    (bus.slave),
    .state_debug(state_debug)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: issue one request while memory is IDLE, time it, check the
  // busywait-low cycle, release the request and step into IDLE again.
  task automatic mem_op(input bit do_rd, input bit do_wr,
                        input logic [ADDR_BITS-1:0] addr,
                        input logic [BLOCK_BITS-1:0] data,
                        input logic [BLOCK_BITS-1:0] exp_rd,
                        input int mode,
                        input logic [ADDR_BITS-1:0] alt_addr,
                        input string tag);
    int  cycles;
    bit  fell;
    bus.read      = do_rd;
    bus.write     = do_wr;
    bus.address   = addr;
    bus.writedata = data;
    #1;
    check({tag, "_busy_comb"}, 32'(bus.busywait), 32'd1);
    cycles = 0;
    fell   = 1'b0;
    for (int i = 0; i < 40 && !fell; i++) begin
      @(posedge clock);
      #1;
      if (!bus.busywait) begin
        fell = 1'b1;
      end else begin
        cycles++;
        if (cycles == 2 && mode == MODE_RETARGET) begin
          bus.address   = alt_addr;
          bus.writedata = ~data;
        end
        if (cycles == 2 && mode == MODE_WITHDRAW) begin
          bus.read  = 1'b0;
          bus.write = 1'b0;
        end
      end
    end
    check({tag, "_busy_fell"}, 32'(fell), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(ACCESS_CYCLES));
    check({tag, "_state_done"}, 32'(state_debug), 32'(ST_DONE));
    check({tag, "_readdata"}, bus.readdata, exp_rd);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    @(posedge clock);
    #1;
    check({tag, "_state_idle"}, 32'(state_debug), 32'(ST_IDLE));
    check({tag, "_readdata_held"}, bus.readdata, exp_rd);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(bus.busywait), 32'd0);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_state", 32'(state_debug), 32'(ST_IDLE));
    bus.read = 1'b1;
    #1;
    check("rst_busy_with_req", 32'(bus.busywait), 32'd0);
    bus.read = 1'b0;
    reset    = 1'b0;
    @(posedge clock);
    #1;

    // Basic write then read with full timing
    mem_op(0, 1, 6'h3A, 32'hDEADBEEF, 32'h00000000, MODE_PLAIN, '0, "wr3a");
    mem_op(1, 0, 6'h3A, 32'h0,        32'hDEADBEEF, MODE_PLAIN, '0, "rd3a");
    // readdata holds across a write to the same block
    mem_op(0, 1, 6'h3A, 32'h12345678, 32'hDEADBEEF, MODE_PLAIN, '0, "wr3a_b");
    mem_op(1, 0, 6'h3A, 32'h0,        32'h12345678, MODE_PLAIN, '0, "rd3a_b");
    // Write-back immediately followed by refill from an unwritten block
    mem_op(0, 1, 6'h11, 32'hAAAA5555, 32'h12345678, MODE_PLAIN, '0, "wb11");
    mem_op(1, 0, 6'h31, 32'h0,        32'h00000000, MODE_PLAIN, '0, "refill31");
    mem_op(1, 0, 6'h11, 32'h0,        32'hAAAA5555, MODE_PLAIN, '0, "rd11");
    // read and write together behave as a write
    mem_op(1, 1, 6'h02, 32'hCAFEF00D, 32'hAAAA5555, MODE_PLAIN, '0, "both02");
    mem_op(1, 0, 6'h02, 32'h0,        32'hCAFEF00D, MODE_PLAIN, '0, "rd02");
    // Address change mid-access is ignored
    mem_op(0, 1, 6'h07, 32'h0BADC0DE, 32'hCAFEF00D, MODE_PLAIN, '0, "wr07");
    mem_op(1, 0, 6'h3A, 32'h0,        32'h12345678, MODE_RETARGET, 6'h07, "rd3a_retarget");
    mem_op(1, 0, 6'h07, 32'h0,        32'h0BADC0DE, MODE_PLAIN, '0, "rd07");
    // Write retargeted mid-access lands at the captured address
    mem_op(0, 1, 6'h0C, 32'h600DF00D, 32'h0BADC0DE, MODE_RETARGET, 6'h0D, "wr0c_retarget");
    mem_op(1, 0, 6'h0C, 32'h0,        32'h600DF00D, MODE_PLAIN, '0, "rd0c");
    mem_op(1, 0, 6'h0D, 32'h0,        32'h00000000, MODE_PLAIN, '0, "rd0d");
    // Withdrawn requests still complete
    mem_op(0, 1, 6'h20, 32'h13572468, 32'h00000000, MODE_WITHDRAW, '0, "wr20_withdraw");
    mem_op(1, 0, 6'h20, 32'h0,        32'h13572468, MODE_WITHDRAW, '0, "rd20_withdraw");
    // Top address boundary
    mem_op(0, 1, 6'h3F, 32'hF0F0A5A5, 32'h13572468, MODE_PLAIN, '0, "wr3f");
    mem_op(1, 0, 6'h3F, 32'h0,        32'hF0F0A5A5, MODE_PLAIN, '0, "rd3f");

    // Reset mid-access of a write to 0x05
    bus.write     = 1'b1;
    bus.address   = 6'h05;
    bus.writedata = 32'h55AA55AA;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("midrst_state_access", 32'(state_debug), 32'(ST_ACCESS));
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busywait), 32'd0);
    check("midrst_readdata", bus.readdata, 32'h0);
    check("midrst_state", 32'(state_debug), 32'(ST_IDLE));
    bus.write = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    mem_op(1, 0, 6'h05, 32'h0, 32'h00000000, MODE_PLAIN, '0, "rd05_after_rst");
    mem_op(1, 0, 6'h3F, 32'h0, 32'h00000000, MODE_PLAIN, '0, "rd3f_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
